mt_regfile_clr: RTL
===================

Name: mt_regfile_clr

Overview:
- Parametrised multithreaded register file, the successor to the fixed 4-thread x 16 x 32 file used by the fine-grained-threaded pipeline.
- Provides 2 combinational read ports and 1 synchronous write port per thread context, with optional write-to-read bypass.
- Adds a hardware clear engine: after reset, all entries are zeroed; on request, a single thread context is zeroed. A busy flag stalls the pipeline while clearing.
- Sits between the decode stage (reads) and the writeback stage (write).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 4, register index width; 2^ADDR_W registers per thread.
- THREAD_W, 2, thread ID width; 2^THREAD_W thread contexts.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see only stored data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high; starts a full-array clear.
- clr_req  in  1  one-cycle pulse requesting a clear of one thread context.
- clr_thread  in  THREAD_W  thread to clear; sampled when clr_req is accepted.
- wena  in  1  write enable.
- w_thread  in  THREAD_W  write thread ID.
- waddr  in  ADDR_W  write register index.
- wdata  in  DATA_W  write data.
- r_thread  in  THREAD_W  read thread ID, shared by both read ports.
- r0addr  in  ADDR_W  read port 0 index.
- r1addr  in  ADDR_W  read port 1 index.
- r0data  out  DATA_W  read port 0 data, combinational.
- r1data  out  DATA_W  read port 1 data, combinational.
- busy  out  1  registered; 1 while a clear is in progress.

Behaviour:
- Storage:
  - DEPTH = 2^(THREAD_W+ADDR_W) entries.
  - Entry index = {thread, addr}.
  - Register index 0 of every thread is hardwired zero: reads return 0 and writes are discarded.
- Write:
  - When wena=1, waddr!=0 and busy=0, the entry {w_thread, waddr} takes wdata at the clock edge.
  - Writes while busy=1 are dropped, not queued. The pipeline must stall on busy.
- Read:
  - Zero-latency combinational read: rNdata = entry{r_thread, rNaddr}.
  - rNaddr==0 returns 0.
  - With BYPASS=1: if wena=1, busy=0, w_thread==r_thread, waddr==rNaddr and waddr!=0, rNdata = wdata in the same cycle.
  - With BYPASS=0, the new value is visible the cycle after the write.
- FSM states: IDLE, CLR_ALL, CLR_THR. Counter cnt is THREAD_W+ADDR_W bits wide.
- reset=1 (any state):
  - Next state is CLR_ALL, cnt=0, busy=1.
  - While reset is held, the FSM holds CLR_ALL with cnt=0.
  - Reset mid-clear restarts the clear from 0.
- CLR_ALL:
  - Each cycle, zero entry[cnt] and increment cnt.
  - After zeroing entry DEPTH-1, go to IDLE and set busy=0.
  - Total is DEPTH cycles after reset deasserts; 64 cycles at default parameters.
- IDLE:
  - clr_req=1 latches clr_thread into thr_q, sets cnt=0, busy=1, and moves to CLR_THR.
- CLR_THR:
  - Each cycle, zero entry {thr_q, cnt[ADDR_W-1:0]}.
  - After index 2^ADDR_W-1 is zeroed, go to IDLE and set busy=0.
  - Total is 2^ADDR_W cycles; 16 at default parameters.
- clr_req while busy=1 is ignored; there is no queueing.
- Reads during a clear:
  - In CLR_ALL, all reads return 0.
  - In CLR_THR, reads with r_thread==thr_q return 0; other threads read normally with no bypass.
- Reset values:
  - busy=1 and state=CLR_ALL at the first edge with reset=1.
  - rNdata=0 throughout reset and CLR_ALL.
  - Array contents are undefined until CLR_ALL completes.
- No X propagation: simulation initial contents must not be relied upon.

Test Plan:
- Reset clear: pulse reset for 2 cycles -> busy=1 for exactly 64 cycles after deassert; then reads of all 64 entries return 0.
- Write/read with BYPASS=1:
  - Write t2 r5=0xDEADBEEF while r_thread=2, r0addr=5 -> r0data=0xDEADBEEF in the same cycle.
  - r1addr=5 in the next cycle -> 0xDEADBEEF.
  - Same test with BYPASS=0 -> 0 in the write cycle, 0xDEADBEEF in the next cycle.
- Zero register: write t1 r0=0x12345678 -> r0data with r_thread=1, r0addr=0 reads 0; bypass is not applied.
- Thread clear:
  - Fill all threads with addr-tagged data, then pulse clr_req with clr_thread=3 -> busy=1 for 16 cycles.
  - Afterwards t3 reads all 0; t0-t2 are unchanged.
  - A t0 read during the clear returns its data.
- Blocking: during a thread clear, issue wena t0 r7=0xAA and a second clr_req -> r7 is unchanged after busy falls, and busy stays 1 for only 16 cycles total.
- Reset mid-clear: assert reset at CLR_THR cycle 8 -> busy stays 1, then a full 64-cycle clear; all entries read 0.

Source files
------------

// File: rtl/mt_regfile_clr.sv
`default_nettype none
// ============================================================================
// Module   : mt_regfile_clr
// Brief    : Multithreaded 2R/1W register file with a hardware clear engine.
//            Reset zeroes the whole array; clr_req zeroes one thread context.
// Revision : 1.0
// ============================================================================
module mt_regfile_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int THREAD_W = 2,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_req,
  input  logic [THREAD_W-1:0] clr_thread,
  input  logic                wena,
  input  logic [THREAD_W-1:0] w_thread,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [THREAD_W-1:0] r_thread,
  input  logic [ADDR_W-1:0]   r0addr,
  input  logic [ADDR_W-1:0]   r1addr,
  output logic [DATA_W-1:0]   r0data,
  output logic [DATA_W-1:0]   r1data,
  output logic                busy
);

  localparam int IDX_W = THREAD_W + ADDR_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_THR = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_cnt;
  logic [THREAD_W-1:0] r_thr_q;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_ok;
  logic                w_clr_en;
  logic [IDX_W-1:0]    w_clr_idx;
  logic                w_rd_blank_all;
  logic                w_rd_blank_thr;
  logic                w_byp0;
  logic                w_byp1;

  assign busy     = r_busy;
  assign w_wr_ok  = wena && (waddr != '0) && !r_busy;
  assign w_clr_en = (r_state == CLR_ALL) || (r_state == CLR_THR);

  always_comb begin
    w_clr_idx = r_cnt;
    if (r_state == CLR_THR) begin
      w_clr_idx = {r_thr_q, r_cnt[ADDR_W-1:0]};
    end
  end

  // Clear engine sequencing; reset from any state restarts the full clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLR_ALL;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_thr_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_thr_q <= clr_thread;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CLR_THR;
          end
        end
        CLR_ALL: begin
          if (r_cnt == '1) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        CLR_THR: begin
          if (r_cnt[ADDR_W-1:0] == '1) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= CLR_ALL;
        end
      endcase
    end
  end

  // Clearing and writing are mutually exclusive because writes require !busy.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[{w_thread, waddr}] <= wdata;
    end
  end

  assign w_rd_blank_all = reset || (r_state == CLR_ALL);
  assign w_rd_blank_thr = (r_state == CLR_THR) && (r_thread == r_thr_q);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_byp0 = w_wr_ok && (w_thread == r_thread) && (waddr == r0addr);
      assign w_byp1 = w_wr_ok && (w_thread == r_thread) && (waddr == r1addr);
    end else begin : g_no_bypass
      assign w_byp0 = 1'b0;
      assign w_byp1 = 1'b0;
    end
  endgenerate

  always_comb begin
    r0data = '0;
    if (!w_rd_blank_all && !w_rd_blank_thr && (r0addr != '0)) begin
      r0data = w_byp0 ? wdata : r_mem[{r_thread, r0addr}];
    end
  end

  always_comb begin
    r1data = '0;
    if (!w_rd_blank_all && !w_rd_blank_thr && (r1addr != '0)) begin
      r1data = w_byp1 ? wdata : r_mem[{r_thread, r1addr}];
    end
  end

endmodule
`default_nettype wire
